lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- HD44780-style character-LCD responder: the display end of the 8-bit RS/RW/DB command bus driven by the team's display control unit.
- Decodes instructions and data writes, and tracks the init sequence.
- Maintains a 2x16 DDRAM image, address counter (AC) and display flags.
- Used as an on-chip display model for self-test, and as a bus checker in simulation.

Parameters:
- FS_COUNT_MIN, 3, number of function-set commands (DB[5:4]=2'b11) required before the block accepts other commands.
- BLANK_CHAR, 8'h20, fill value written to DDRAM by Clear Display and by reset.

Ports:
- clock500Hz  input  1  system clock; all bus transfers are sampled on its rising edge.
- reset  input  1  asynchronous, active-high.
- en  input  1  bus-transfer qualifier; a transfer occurs on a rising edge with en=1. Tied high when connected to the display control unit.
- RS  input  1  0 = instruction, 1 = data.
- RW  input  1  0 = write, 1 = read (reads unsupported).
- DB  input  8  instruction or data byte.
- rd_index  input  5  DDRAM read index: 0-15 = line 1, 16-31 = line 2.
- rd_char  output  8  combinational DDRAM[rd_index].
- ac  output  7  address counter.
- display_on, cursor_on, blink_on  output  1 each  from Display Control D, C, B.
- inc_mode  output  1  Entry Mode I/D.
- configured  output  1  init sequence complete.
- char_wr  output  1  one-cycle pulse after each accepted data write.
- protocol_err  output  1  sticky error flag.

Behaviour:
- Reset (async):
  - DDRAM all BLANK_CHAR, ac=7'h00, inc_mode=1.
  - display_on, cursor_on, blink_on, configured, char_wr, protocol_err all 0.
  - FSM to WAIT_FS, fs_cnt=0.
- Transfer: evaluated only at a rising edge with en=1. Results are visible on registered outputs after that edge (one-cycle latency). char_wr is high for exactly the following cycle.
- RW=1: transfer ignored, protocol_err<=1.
- FSM states:
  - WAIT_FS:
    - Instruction with DB[7:6]=00 and DB[5:4]=11 increments fs_cnt, saturating at FS_COUNT_MIN.
    - On reaching FS_COUNT_MIN, go to READY and set configured=1.
    - Any other transfer is ignored and sets protocol_err.
  - READY: full decode. Function sets remain legal here and are no-ops.
- Instruction decode in READY, by highest set DB bit:
  - bit7, Set DDRAM: addr=DB[6:0].
    - Legal ranges are 0x00-0x0F and 0x40-0x4F; a legal addr loads ac.
    - Otherwise ac is unchanged and protocol_err<=1.
  - bit6, Set CGRAM: ignored, no error.
  - bit5, Function Set: no-op.
  - bit4, Cursor/Display Shift: ignored.
  - bit3, Display Control: display_on<=DB[2], cursor_on<=DB[1], blink_on<=DB[0].
  - bit2, Entry Mode: inc_mode<=DB[1]; S bit ignored.
  - bit1, Return Home: ac<=0; DDRAM unchanged.
  - bit0, Clear Display: all 32 DDRAM entries<=BLANK_CHAR, ac<=0, inc_mode<=1, all in one edge.
  - DB=0: no-op.
- Data write (RS=1, RW=0) in READY:
  - DDRAM[idx(ac)]<=DB, then ac advances.
  - idx = ac[6] ? 16+ac[3:0] : ac[3:0].
  - Increment (inc_mode=1): 0x0F->0x40, 0x4F->0x00, else +1.
  - Decrement (inc_mode=0): 0x00->0x4F, 0x40->0x0F, else -1.
  - char_wr pulses.
- ac never holds an illegal value.
- protocol_err clears only on reset.
- en=0: no state change; char_wr returns to 0.
- Reset mid-sequence:
  - Returns to WAIT_FS and blanks DDRAM.
  - A partially applied command has no effect.
- rd_char is a combinational read of current DDRAM. A same-edge write is visible after the edge.

Test Plan:
- Controller init stream 38,38,38,38,01,0C,06 (RS=0), then 16 data bytes "HELLO WORLD 0123" -> configured=1 after 3rd 38; display_on=1, cursor_on=0; DDRAM[0..15] = string; ac=0x0F->0x40 after 16th write; 16 char_wr pulses; protocol_err=0.
- Continue with C0 then 16 bytes 0x41..0x50, then 80 -> DDRAM[16..31]=0x41..0x50; ac=0x00 after 80; line 1 unchanged.
- Before init, send RS=1 data 0x41 and instruction 0C -> DDRAM unchanged, display_on=0, protocol_err=1, configured=0.
- After init: 04 (decrement), 80, write 0x5A -> DDRAM[0]=0x5A, ac=0x4F. Write 0x59 -> DDRAM[31]=0x59, ac=0x4E.
- After init, send 90 (addr 0x10) and RW=1 transfer -> ac unchanged, protocol_err=1. Then 01 -> all 32 entries 0x20, ac=0, inc_mode=1.
- Assert reset mid-stream after 8 chars, then hold en=0 for 5 cycles -> all outputs at reset values, DDRAM all 0x20, no char_wr pulses.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: display end of the HD44780-style RS/RW/DB command bus.
// Decodes instructions/data, tracks the function-set init sequence and keeps a 2x16 DDRAM image.
module lcd_bus_responder #(
    parameter int unsigned FS_COUNT_MIN = 3,
    parameter logic [7:0]  BLANK_CHAR   = 8'h20
) (
    input  logic       clock500Hz,
    input  logic       reset,
    input  logic       en,
    input  logic       RS,
    input  logic       RW,
    input  logic [7:0] DB,
    input  logic [4:0] rd_index,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       configured,
    output logic       char_wr,
    output logic       protocol_err
);

    localparam int unsigned FS_W = (FS_COUNT_MIN < 1) ? 1 : $clog2(FS_COUNT_MIN + 1);

    typedef enum logic {
        WAIT_FS,
        READY
    } state_t;

    state_t          state, state_next;
    logic [FS_W-1:0] fs_cnt, fs_cnt_next;
    logic [7:0]      ddram [32];
    logic [4:0]      wr_idx;

    logic [6:0] ac_next;
    logic       display_on_next, cursor_on_next, blink_on_next;
    logic       inc_mode_next, configured_next, char_wr_next, protocol_err_next;
    logic       ram_we, ram_clear;

    // ac only ever holds 0x00-0x0F or 0x40-0x4F, so the line wraps key off ac[3:0] and ac[6].
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            r = (a[3:0] == 4'hF) ? {~a[6], 6'b000000} : a + 7'd1;
        end else begin
            r = (a[3:0] == 4'h0) ? {~a[6], 2'b00, 4'hF} : a - 7'd1;
        end
        return r;
    endfunction

    assign wr_idx = {ac[6], ac[3:0]};

    always_ff @(posedge clock500Hz or posedge reset) begin
        if (reset) begin
            state <= WAIT_FS;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        fs_cnt_next       = fs_cnt;
        ac_next           = ac;
        display_on_next   = display_on;
        cursor_on_next    = cursor_on;
        blink_on_next     = blink_on;
        inc_mode_next     = inc_mode;
        configured_next   = configured;
        protocol_err_next = protocol_err;
        char_wr_next      = 1'b0;
        ram_we            = 1'b0;
        ram_clear         = 1'b0;

        if (en) begin
            if (RW) begin
                protocol_err_next = 1'b1;
            end else if (state == WAIT_FS) begin
                if (!RS && DB[7:4] == 4'b0011) begin
                    if (32'(fs_cnt) + 32'd1 >= FS_COUNT_MIN) begin
                        fs_cnt_next     = FS_W'(FS_COUNT_MIN);
                        state_next      = READY;
                        configured_next = 1'b1;
                    end else begin
                        fs_cnt_next = fs_cnt + FS_W'(1);
                    end
                end else begin
                    protocol_err_next = 1'b1;
                end
            end else if (RS) begin
                ram_we       = 1'b1;
                char_wr_next = 1'b1;
                ac_next      = ac_step(ac, inc_mode);
            end else begin
                priority casez (DB)
                    8'b1???????: begin
                        // legal DDRAM addresses are exactly those with DB[5:4] clear
                        if (DB[5:4] == 2'b00) begin
                            ac_next = DB[6:0];
                        end else begin
                            protocol_err_next = 1'b1;
                        end
                    end
                    8'b01??????, 8'b001?????, 8'b0001????: begin
                    end
                    8'b00001???: begin
                        display_on_next = DB[2];
                        cursor_on_next  = DB[1];
                        blink_on_next   = DB[0];
                    end
                    8'b000001??: begin
                        inc_mode_next = DB[1];
                    end
                    8'b0000001?: begin
                        ac_next = '0;
                    end
                    8'b00000001: begin
                        ram_clear     = 1'b1;
                        ac_next       = '0;
                        inc_mode_next = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock500Hz or posedge reset) begin
        if (reset) begin
            fs_cnt       <= '0;
            ac           <= '0;
            display_on   <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            inc_mode     <= 1'b1;
            configured   <= 1'b0;
            char_wr      <= 1'b0;
            protocol_err <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) begin
                ddram[i] <= BLANK_CHAR;
            end
        end else begin
            fs_cnt       <= fs_cnt_next;
            ac           <= ac_next;
            display_on   <= display_on_next;
            cursor_on    <= cursor_on_next;
            blink_on     <= blink_on_next;
            inc_mode     <= inc_mode_next;
            configured   <= configured_next;
            char_wr      <= char_wr_next;
            protocol_err <= protocol_err_next;
            if (ram_clear) begin
                for (int unsigned i = 0; i < 32; i++) begin
                    ddram[i] <= BLANK_CHAR;
                end
            end else if (ram_we) begin
                ddram[wr_idx] <= DB;
            end
        end
    end

    always_comb begin
        rd_char = ddram[rd_index];
    end

    ac_legal: assert property (@(posedge clock500Hz) disable iff (reset) ac[5:4] == 2'b00);

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: directed controller streams plus random
// traffic, compared against a position-based (0..31) display model.
module tb_lcd_bus_responder;

    localparam int FS_MIN = 3;

    logic       clock500Hz = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       RS = 1'b0;
    logic       RW = 1'b0;
    logic [7:0] DB = 8'h00;
    logic [4:0] rd_index = 5'd0;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       display_on, cursor_on, blink_on, inc_mode, configured, char_wr, protocol_err;

    lcd_bus_responder #(
        .FS_COUNT_MIN(FS_MIN),
        .BLANK_CHAR  (8'h20)
    ) dut (
        .clock500Hz  (clock500Hz),
        .reset       (reset),
        .en          (en),
        .RS          (RS),
        .RW          (RW),
        .DB          (DB),
        .rd_index    (rd_index),
        .rd_char     (rd_char),
        .ac          (ac),
        .display_on  (display_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .inc_mode    (inc_mode),
        .configured  (configured),
        .char_wr     (char_wr),
        .protocol_err(protocol_err)
    );

    always #5 clock500Hz = ~clock500Hz;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulses = 0;

    // Reference model: cursor is a linear position 0..31 across both lines.
    logic [7:0] m_ram [32];
    int         m_pos, m_fs;
    bit         m_inc, m_don, m_con, m_bon, m_cfg, m_err, m_cw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] m_ac();
        return (m_pos < 16) ? 7'(m_pos) : 7'(m_pos - 16 + 64);
    endfunction

    task automatic model_reset();
        foreach (m_ram[i]) m_ram[i] = 8'h20;
        m_pos = 0; m_fs = 0; m_inc = 1;
        m_don = 0; m_con = 0; m_bon = 0; m_cfg = 0; m_err = 0; m_cw = 0;
    endtask

    task automatic model_xfer(input logic rs, input logic rw, input logic [7:0] db);
        int a;
        m_cw = 0;
        if (rw) begin
            m_err = 1;
        end else if (!m_cfg) begin
            if (!rs && db[7:4] == 4'h3) begin
                m_fs++;
                if (m_fs >= FS_MIN) m_cfg = 1;
            end else begin
                m_err = 1;
            end
        end else if (rs) begin
            m_ram[m_pos] = db;
            m_pos = m_inc ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
            m_cw = 1;
        end else if (db[7]) begin
            a = int'(db[6:0]);
            if (a < 16) m_pos = a;
            else if (a >= 64 && a < 80) m_pos = a - 48;
            else m_err = 1;
        end else if (db[6:4] != 3'b000) begin
        end else if (db[3]) begin
            m_don = db[2]; m_con = db[1]; m_bon = db[0];
        end else if (db[2]) begin
            m_inc = db[1];
        end else if (db[1]) begin
            m_pos = 0;
        end else if (db[0]) begin
            foreach (m_ram[i]) m_ram[i] = 8'h20;
            m_pos = 0;
            m_inc = 1;
        end
    endtask

    task automatic check_all(input string tag);
        int k;
        check({tag, " ac"}, 32'(ac), 32'(m_ac()));
        check({tag, " dcb"}, 32'({display_on, cursor_on, blink_on}), 32'({m_don, m_con, m_bon}));
        check({tag, " inc"}, 32'(inc_mode), 32'(m_inc));
        check({tag, " cfg"}, 32'(configured), 32'(m_cfg));
        check({tag, " err"}, 32'(protocol_err), 32'(m_err));
        check({tag, " char_wr"}, 32'(char_wr), 32'(m_cw));
        k = $urandom_range(0, 31);
        rd_index = 5'(k);
        #1;
        check({tag, " ram"}, 32'(rd_char), 32'(m_ram[k]));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_index = 5'(i);
            #1;
            check($sformatf("%s ram[%0d]", tag, i), 32'(rd_char), 32'(m_ram[i]));
        end
    endtask

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] db);
        @(negedge clock500Hz);
        en = 1; RS = rs; RW = rw; DB = db;
        @(posedge clock500Hz);
        model_xfer(rs, rw, db);
        #1;
        en = 0;
        if (char_wr) n_pulses++;
        check_all($sformatf("xfer rs%0d rw%0d %02h", rs, rw, db));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock500Hz);
            en = 0; RS = 1'($urandom); RW = 1'($urandom); DB = 8'($urandom);
            @(posedge clock500Hz);
            #1;
            m_cw = 0;
            if (char_wr) n_pulses++;
            check_all("idle");
        end
    endtask

    // busy=1 asserts reset while a data write is presented on the bus
    task automatic do_reset(input bit busy);
        @(negedge clock500Hz);
        if (busy) begin
            en = 1; RS = 1; RW = 0; DB = 8'h58;
        end
        #2;
        reset = 1;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clock500Hz);
        #1;
        en = 0;
        @(negedge clock500Hz);
        reset = 0;
    endtask

    task automatic clean_op();
        int c;
        logic [7:0] b;
        c = $urandom_range(0, 11);
        b = 8'($urandom);
        case (c)
            0, 1, 2, 3, 4: xfer(1, 0, b);
            5:  xfer(0, 0, {1'b1, b[6], 2'b00, b[3:0]});
            6:  xfer(0, 0, {5'b00001, b[2:0]});
            7:  xfer(0, 0, {6'b000001, b[1:0]});
            8:  xfer(0, 0, {7'b0000001, b[0]});
            9:  xfer(0, 0, 8'h01);
            10: xfer(0, 0, {2'b01, b[5:0]});
            default: xfer(0, 0, {2'b00, b[5:0]});
        endcase
    endtask

    task automatic init_stream();
        logic [7:0] seq [7];
        seq = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h01, 8'h0C, 8'h06};
        for (int i = 0; i < 7; i++) begin
            xfer(0, 0, seq[i]);
            if (i == 1) check("cfg after 2nd 38", 32'(configured), 32'd0);
            if (i == 2) check("cfg after 3rd 38", 32'(configured), 32'd1);
        end
    endtask

    initial begin
        string msg;
        msg = "HELLO WORLD 0123";
        model_reset();

        // Reset state and pre-init misuse
        do_reset(0);
        sweep("post-reset");
        xfer(1, 0, 8'h41);
        xfer(0, 0, 8'h0C);
        check("preinit err", 32'(protocol_err), 32'd1);
        check("preinit cfg", 32'(configured), 32'd0);
        check("preinit disp", 32'(display_on), 32'd0);
        sweep("preinit");

        // Controller init and two full lines
        do_reset(0);
        n_pulses = 0;
        init_stream();
        check("disp on", 32'({display_on, cursor_on}), 32'b10);
        for (int i = 0; i < 16; i++) xfer(1, 0, msg[i]);
        check("ac after line1", 32'(ac), 32'h40);
        check("line1 pulses", 32'(n_pulses), 32'd16);
        check("line1 err", 32'(protocol_err), 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd_index = 5'(i);
            #1;
            check($sformatf("line1 char %0d", i), 32'(rd_char), 32'(msg[i]));
        end
        xfer(0, 0, 8'hC0);
        for (int i = 0; i < 16; i++) xfer(1, 0, 8'(8'h41 + i));
        xfer(0, 0, 8'h80);
        check("ac after 80", 32'(ac), 32'h00);
        for (int i = 0; i < 16; i++) begin
            rd_index = 5'(16 + i);
            #1;
            check($sformatf("line2 char %0d", i), 32'(rd_char), 32'(8'h41 + i));
        end
        sweep("two lines");

        // Decrement wrap across both line boundaries
        xfer(0, 0, 8'h04);
        xfer(0, 0, 8'h80);
        xfer(1, 0, 8'h5A);
        check("dec ac 4F", 32'(ac), 32'h4F);
        xfer(1, 0, 8'h59);
        check("dec ac 4E", 32'(ac), 32'h4E);
        rd_index = 5'd0; #1;
        check("dec ram0", 32'(rd_char), 32'h5A);
        rd_index = 5'd31; #1;
        check("dec ram31", 32'(rd_char), 32'h59);

        // Illegal address, read transfer, then clear
        xfer(0, 0, 8'h90);
        check("bad addr ac", 32'(ac), 32'h4E);
        check("bad addr err", 32'(protocol_err), 32'd1);
        xfer(0, 1, 8'h00);
        xfer(0, 0, 8'h01);
        check("clear ac", 32'(ac), 32'h00);
        check("clear inc", 32'(inc_mode), 32'd1);
        sweep("clear");

        // Reset mid-stream followed by idle bus
        do_reset(0);
        init_stream();
        for (int i = 0; i < 8; i++) xfer(1, 0, msg[i]);
        do_reset(1);
        n_pulses = 0;
        idle(5);
        check("idle pulses", 32'(n_pulses), 32'd0);
        check("midrst cfg", 32'(configured), 32'd0);
        sweep("midrst");

        // Random traffic: legal-only, then arbitrary (last run without init)
        for (int r = 0; r < 4; r++) begin
            do_reset(0);
            if (r != 3) begin
                for (int i = 0; i < FS_MIN; i++) xfer(0, 0, 8'h30 | 8'($urandom_range(0, 15)));
            end
            for (int i = 0; i < 250; i++) begin
                if (r < 2) clean_op();
                else xfer(1'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom));
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
            end
            sweep($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
